// File: rtl/sync_fifo_pack.sv
// Single-clock FIFO that packs narrow write words into wide read words.
// Only complete wide words are visible to the reader; a partial word stays internal.
module sync_fifo_pack #(
    parameter int    INPUT_WIDTH  = 8,
    parameter int    OUTPUT_WIDTH = 64,
    parameter int    WR_DEPTH     = 128,
    parameter int    RD_DEPTH     = 16,
    parameter string MODE         = "Standard",
    parameter string DIRECTION    = "LSB"
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          wr_en,
    input  logic [INPUT_WIDTH-1:0]        din,
    input  logic                          rd_en,
    output logic [OUTPUT_WIDTH-1:0]       dout,
    output logic                          valid,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          underflow,
    output logic [$clog2(WR_DEPTH):0]     wr_data_count,
    output logic [$clog2(RD_DEPTH):0]     rd_data_count,
    output logic [$clog2(WR_DEPTH):0]     wr_data_space
);

    localparam int RATIO  = OUTPUT_WIDTH / INPUT_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int WC_W   = $clog2(WR_DEPTH) + 1;
    localparam int RC_W   = $clog2(RD_DEPTH) + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [WC_W-1:0]   WC_RATIO  = WC_W'(RATIO);
    localparam logic [WC_W-1:0]   WC_FULL   = WC_W'(WR_DEPTH);

    logic [OUTPUT_WIDTH-1:0] r_mem [RD_DEPTH];
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W-1:0]        r_rdPtr;
    logic [LANE_W-1:0]       r_lane;
    logic [WC_W-1:0]         r_wrCount;
    logic [RC_W-1:0]         r_rdCount;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_wrAccept;
    logic                    w_rdAccept;
    logic                    w_wordDone;
    logic [LANE_W-1:0]       w_laneSel;
    logic [WC_W-1:0]         w_wrCountNext;
    logic [RC_W-1:0]         w_rdCountNext;
    logic [OUTPUT_WIDTH-1:0] w_headWord;

    // Gating looks only at the registered flags, so a same-cycle pop never rescues a push.
    assign w_wrAccept = wr_en & ~r_full;
    assign w_rdAccept = rd_en & ~r_empty;
    assign w_wordDone = w_wrAccept & (r_lane == LAST_LANE);
    assign w_laneSel  = (DIRECTION == "MSB") ? (LAST_LANE - r_lane) : r_lane;
    assign w_headWord = r_mem[r_rdPtr];

    always_comb begin
        w_wrCountNext = r_wrCount;
        w_rdCountNext = r_rdCount;
        if (w_wrAccept) w_wrCountNext = w_wrCountNext + WC_W'(1);
        if (w_rdAccept) w_wrCountNext = w_wrCountNext - WC_RATIO;
        if (w_wordDone) w_rdCountNext = w_rdCountNext + RC_W'(1);
        if (w_rdAccept) w_rdCountNext = w_rdCountNext - RC_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (w_wrAccept)
            r_mem[r_wrPtr][w_laneSel*INPUT_WIDTH +: INPUT_WIDTH] <= din;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_lane      <= '0;
            r_wrCount   <= '0;
            r_rdCount   <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_lane <= w_wordDone ? '0 : r_lane + LANE_W'(1);
                if (w_wordDone) r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_rdAccept) r_rdPtr <= r_rdPtr + PTR_W'(1);
            r_wrCount   <= w_wrCountNext;
            r_rdCount   <= w_rdCountNext;
            r_full      <= (w_wrCountNext == WC_FULL);
            r_empty     <= (w_rdCountNext == '0);
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
        end
    end

    // FWFT exposes the head word combinationally; Standard registers it on each pop.
    if (MODE == "FWFT") begin : g_fwft
        assign valid = ~r_empty;
        assign dout  = r_empty ? '0 : w_headWord;
    end else begin : g_std
        logic [OUTPUT_WIDTH-1:0] r_dout;
        logic                    r_valid;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                r_dout  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rdAccept;
                if (w_rdAccept) r_dout <= w_headWord;
            end
        end

        assign valid = r_valid;
        assign dout  = r_dout;
    end

    assign full          = r_full;
    assign empty         = r_empty;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;
    assign wr_data_count = r_wrCount;
    assign rd_data_count = r_rdCount;
    assign wr_data_space = WC_FULL - r_wrCount;

endmodule

// File: tb/tb_sync_fifo_pack.sv
// Bench for sync_fifo_pack: an LSB/Standard and an MSB/FWFT instance share one
// stimulus stream and are compared against a byte-queue model every cycle.
module tb_sync_fifo_pack;

    localparam int IW    = 8;
    localparam int OW    = 64;
    localparam int RATIO = OW / IW;
    localparam int WRD   = 128;
    localparam int RDD   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic        rdEn;
    logic [7:0]  din;

    logic [63:0] doutS, doutF;
    logic        validS, validF, fullS, fullF, emptyS, emptyF;
    logic        ovfS, ovfF, udfS, udfF;
    logic [7:0]  wcS, wcF, wsS, wsF;
    logic [4:0]  rcS, rcF;

    int          errors = 0;
    int          checks = 0;

    byte unsigned q[$];
    logic [63:0] expDoutS;
    logic        expValidS;
    logic        expOvf;
    logic        expUdf;
    bit          fwftSeen;

    always #5 clk = ~clk;

    sync_fifo_pack #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .WR_DEPTH(WRD), .RD_DEPTH(RDD),
                     .MODE("Standard"), .DIRECTION("LSB")) dutS (
        .sys_clk(clk), .sys_rst(rst), .wr_en(wrEn), .din(din), .rd_en(rdEn),
        .dout(doutS), .valid(validS), .full(fullS), .empty(emptyS),
        .overflow(ovfS), .underflow(udfS), .wr_data_count(wcS),
        .rd_data_count(rcS), .wr_data_space(wsS));

    sync_fifo_pack #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .WR_DEPTH(WRD), .RD_DEPTH(RDD),
                     .MODE("FWFT"), .DIRECTION("MSB")) dutF (
        .sys_clk(clk), .sys_rst(rst), .wr_en(wrEn), .din(din), .rd_en(rdEn),
        .dout(doutF), .valid(validF), .full(fullF), .empty(emptyF),
        .overflow(ovfF), .underflow(udfF), .wr_data_count(wcF),
        .rd_data_count(rcF), .wr_data_space(wsF));

    // Oldest complete word in the model, in LSB-first or MSB-first byte order.
    function automatic logic [63:0] headWord(input bit msbFirst);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (msbFirst) w = {w[55:0], q[i]};
            else          w = w | (64'(q[i]) << (8 * i));
        end
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAllOutputs();
        int n;
        n = q.size();
        checkOutput("wcS",   wcS,   64'(n));
        checkOutput("rcS",   rcS,   64'(n / RATIO));
        checkOutput("wsS",   wsS,   64'(WRD - n));
        checkOutput("fullS", fullS, 64'(n == WRD));
        checkOutput("emptyS",emptyS,64'(n < RATIO));
        checkOutput("ovfS",  ovfS,  64'(expOvf));
        checkOutput("udfS",  udfS,  64'(expUdf));
        checkOutput("validS",validS,64'(expValidS));
        checkOutput("doutS", doutS, expDoutS);
        checkOutput("wcF",   wcF,   64'(n));
        checkOutput("rcF",   rcF,   64'(n / RATIO));
        checkOutput("wsF",   wsF,   64'(WRD - n));
        checkOutput("fullF", fullF, 64'(n == WRD));
        checkOutput("emptyF",emptyF,64'(n < RATIO));
        checkOutput("ovfF",  ovfF,  64'(expOvf));
        checkOutput("udfF",  udfF,  64'(expUdf));
        checkOutput("validF",validF,64'(n >= RATIO));
        if (n >= RATIO)     checkOutput("doutF", doutF, headWord(1'b1));
        else if (!fwftSeen) checkOutput("doutF0", doutF, 64'h0);
    endtask

    // One clock of stimulus; the model decides acceptance from its pre-edge occupancy.
    task automatic applyStimulus(input bit we, input logic [7:0] d, input bit re);
        bit wAcc, rAcc;
        wrEn = we; din = d; rdEn = re;
        wAcc = we && (q.size() < WRD);
        rAcc = re && (q.size() >= RATIO);
        expOvf    = we && !wAcc;
        expUdf    = re && !rAcc;
        expValidS = rAcc;
        if (rAcc) expDoutS = headWord(1'b0);
        @(posedge clk);
        #1;
        if (rAcc) for (int i = 0; i < RATIO; i++) void'(q.pop_front());
        if (wAcc) q.push_back(d);
        if (q.size() >= RATIO) fwftSeen = 1'b1;
        checkAllOutputs();
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible at once.
    task automatic applyReset();
        wrEn = 1'b0; rdEn = 1'b0; din = '0;
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        expDoutS = '0; expValidS = 1'b0; expOvf = 1'b0; expUdf = 1'b0; fwftSeen = 1'b0;
        checkAllOutputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkAllOutputs();
    endtask

    initial begin
        rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; din = '0;
        @(posedge clk);
        #1;
        applyReset();

        $display("[TB] basic pack and pop");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("t1word", doutF, 64'h0102030405060708);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1dout", doutS, 64'h0807060504030201);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] partial word and underflow");
        applyStimulus(1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        applyStimulus(1'b1, 8'hB8, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        $display("[TB] fill to capacity");
        applyReset();
        for (int i = 0; i < WRD; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput("t4first", doutS, 64'h0706050403020100);
        for (int i = 1; i < RDD; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4last", doutS, 64'h7F7E7D7C7B7A7978);
        applyStimulus(1'b0, 8'h00, 1'b1);

        $display("[TB] concurrent traffic across wrap");
        for (int i = 0; i < 4 * RATIO; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        for (int rep = 0; rep < 3; rep++)
            for (int c = 0; c < 40; c++)
                applyStimulus(1'b1, 8'($urandom), $urandom_range(0, 7) == 0);
        for (int c = 0; c < 400; c++)
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0);

        $display("[TB] reset mid-operation");
        applyReset();
        for (int i = 0; i < 5 * RATIO + 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
        checkOutput("t6words", rcS, 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t6dout", doutS, 64'hC7C6C5C4C3C2C1C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
